// File: rtl/circuit_1_vector_checker.sv
// Exhaustive stimulus/response checker for the 3-input gate network circuit_1.
// Walks {a,b,c} through 0..7, samples o after a settle window, scores it against GOLDEN.
module circuit_1_vector_checker #(
    parameter int unsigned SETTLE_CYCLES = 4,
    parameter logic [7:0]  GOLDEN        = 8'hAB
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       dut_o,
    output logic       a,
    output logic       b,
    output logic       c,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] err_count,
    output logic [7:0] fail_mask
);

    localparam int unsigned CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CW-1:0] LAST_SETTLE = CW'(SETTLE_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_APPLY,
        S_SETTLE,
        S_SAMPLE,
        S_DONE
    } state_t;

    state_t        r_state;
    logic [2:0]    r_vec_idx;
    logic [CW-1:0] r_settle_cnt;
    logic [2:0]    r_abc;
    logic          r_busy;
    logic          r_done;
    logic          r_pass;
    logic [3:0]    r_err_count;
    logic [7:0]    r_fail_mask;

    logic          w_mismatch;
    logic [2:0]    w_vec_next;

    assign w_mismatch = (dut_o != GOLDEN[r_vec_idx]);
    assign w_vec_next = r_vec_idx + 3'd1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_vec_idx    <= 3'd0;
            r_settle_cnt <= '0;
            r_abc        <= 3'd0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_pass       <= 1'b0;
            r_err_count  <= 4'd0;
            r_fail_mask  <= 8'h00;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state     <= S_APPLY;
                        r_vec_idx   <= 3'd0;
                        r_abc       <= 3'd0;
                        r_busy      <= 1'b1;
                        r_pass      <= 1'b0;
                        r_err_count <= 4'd0;
                        r_fail_mask <= 8'h00;
                    end
                end
                S_APPLY: begin
                    r_settle_cnt <= '0;
                    r_state      <= S_SETTLE;
                end
                S_SETTLE: begin
                    if (r_settle_cnt == LAST_SETTLE) begin
                        r_state <= S_SAMPLE;
                    end else begin
                        r_settle_cnt <= r_settle_cnt + 1'b1;
                    end
                end
                S_SAMPLE: begin
                    if (w_mismatch) begin
                        r_fail_mask[r_vec_idx] <= 1'b1;
                        r_err_count            <= r_err_count + 4'd1;
                    end
                    // pass must include the verdict of this final sample
                    if (r_vec_idx == 3'd7) begin
                        r_state <= S_DONE;
                        r_abc   <= 3'd0;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_pass  <= (r_err_count == 4'd0) && !w_mismatch;
                    end else begin
                        r_vec_idx <= w_vec_next;
                        r_abc     <= w_vec_next;
                        r_state   <= S_APPLY;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign a         = r_abc[2];
    assign b         = r_abc[1];
    assign c         = r_abc[0];
    assign busy      = r_busy;
    assign done      = r_done;
    assign pass      = r_pass;
    assign err_count = r_err_count;
    assign fail_mask = r_fail_mask;

endmodule

// File: tb/tb_circuit_1_vector_checker.sv
// Bench for circuit_1_vector_checker: table of DUT fault models, scoreboarded
// pass results and a per-cycle a/b/c sequence monitor.
module tb_circuit_1_vector_checker;

    localparam int unsigned S = 4;
    localparam logic [7:0] TT = 8'hAB;
    localparam int DONE_EDGE = 49;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic       dut_o;
    logic       a, b, c;
    logic       busy, done, pass;
    logic [3:0] err_count;
    logic [7:0] fail_mask;

    int n_cmp = 0;
    int n_bad = 0;

    // 0 good, 1 tied1, 2 tied0, 3 inverted, 4 invert one vector
    int         mode = 0;
    logic [2:0] flip = 3'd0;

    typedef struct {
        int         mode;
        logic [2:0] flip;
        logic [7:0] mask;
        logic [3:0] errs;
        logic       pass;
        string      name;
    } vec_t;

    typedef struct {
        logic [7:0] mask;
        logic [3:0] errs;
        logic       pass;
    } res_t;

    res_t       res_q[$];
    logic [2:0] abc_q[$];

    circuit_1_vector_checker #(
        .SETTLE_CYCLES(S),
        .GOLDEN(TT)
    ) u_dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .dut_o(dut_o),
        .a(a),
        .b(b),
        .c(c),
        .busy(busy),
        .done(done),
        .pass(pass),
        .err_count(err_count),
        .fail_mask(fail_mask)
    );

    always #5 clk = ~clk;

    always_comb begin
        logic [7:0] tt;
        tt = TT;
        dut_o = tt[{a, b, c}];
        case (mode)
            1: dut_o = 1'b1;
            2: dut_o = 1'b0;
            3: dut_o = ~tt[{a, b, c}];
            4: dut_o = tt[{a, b, c}] ^ ({a, b, c} == flip);
            default: dut_o = tt[{a, b, c}];
        endcase
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Sequence monitor: a,b,c must follow the queued pattern while busy, 0 otherwise
    always @(negedge clk) begin
        if (!rst) begin
            if (busy) begin
                if (abc_q.size() == 0) begin
                    chk("abc_extra", {29'd0, a, b, c}, 32'hDEAD);
                end else begin
                    chk("abc_seq", {29'd0, a, b, c}, {29'd0, abc_q.pop_front()});
                end
            end else begin
                chk("abc_idle", {29'd0, a, b, c}, 32'd0);
            end
            chk("popcount", {28'd0, err_count}, $countones(fail_mask));
        end
    end

    task automatic push_abc();
        for (int v = 0; v < 8; v++)
            for (int k = 0; k < int'(S) + 2; k++)
                abc_q.push_back(3'(v));
    endtask

    // inj: edge number at which an extra start is offered (0 = none)
    task automatic run_pass(input vec_t t, input int inj);
        res_t r;
        int   n;
        mode = t.mode;
        flip = t.flip;
        r.mask = t.mask;
        r.errs = t.errs;
        r.pass = t.pass;
        res_q.push_back(r);
        push_abc();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        n = 1;
        forever begin
            @(negedge clk);
            start = (inj != 0) && (n == inj);
            if (done) break;
            if (n >= 200) begin
                chk({t.name, "_timeout"}, 32'(n), DONE_EDGE);
                break;
            end
            @(posedge clk);
            n++;
        end
        chk({t.name, "_latency"}, 32'(n), DONE_EDGE);
        if (res_q.size() != 0) begin
            r = res_q.pop_front();
            chk({t.name, "_mask"}, {24'd0, fail_mask}, {24'd0, r.mask});
            chk({t.name, "_errs"}, {28'd0, err_count}, {28'd0, r.errs});
            chk({t.name, "_pass"}, {31'd0, pass}, {31'd0, r.pass});
        end
        chk({t.name, "_busy_done"}, {31'd0, busy}, 32'd0);
        @(negedge clk);
        start = 1'b0;
        chk({t.name, "_done_pulse"}, {31'd0, done}, 32'd0);
        chk({t.name, "_pass_held"}, {31'd0, pass}, {31'd0, t.pass});
        chk({t.name, "_mask_held"}, {24'd0, fail_mask}, {24'd0, t.mask});
    endtask

    task automatic reset_mid_cycle(input string name);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk({name, "_zero"},
            {20'd0, a, b, c, busy, done, pass, err_count, fail_mask}, 32'd0);
        @(negedge clk);
        #1 rst = 1'b0;
        abc_q.delete();
        res_q.delete();
    endtask

    vec_t tbl[6];

    initial begin
        tbl[0] = '{0, 3'd0, 8'h00, 4'd0, 1'b1, "good"};
        tbl[1] = '{1, 3'd0, 8'h54, 4'd3, 1'b0, "tied1"};
        tbl[2] = '{2, 3'd0, 8'hAB, 4'd5, 1'b0, "tied0"};
        tbl[3] = '{3, 3'd0, 8'hFF, 4'd8, 1'b0, "inverted"};
        tbl[4] = '{4, 3'd5, 8'h20, 4'd1, 1'b0, "flip5"};
        tbl[5] = '{4, 3'd0, 8'h01, 4'd1, 1'b0, "flip0"};

        #2 rst = 1'b1;
        #1;
        chk("reset_zero",
            {20'd0, a, b, c, busy, done, pass, err_count, fail_mask}, 32'd0);
        @(negedge clk);
        #1 rst = 1'b0;

        for (int i = 0; i < 6; i++) run_pass(tbl[i], 0);

        // extra starts during vector 2 and during DONE must be ignored
        run_pass('{1, 3'd0, 8'h54, 4'd3, 1'b0, "inj"}, 15);
        run_pass('{0, 3'd0, 8'h00, 4'd0, 1'b1, "inj_done"}, DONE_EDGE);

        // abort at vector 3 after two live mismatches, then a fresh clean pass
        mode = 2;
        push_abc();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int n = 1; n < 20; n++) begin
            @(negedge clk);
            start = (n == 15);
            @(posedge clk);
        end
        #1 start = 1'b0;
        @(negedge clk);
        chk("abort_live_mask", {24'd0, fail_mask}, 32'h03);
        chk("abort_live_errs", {28'd0, err_count}, 32'd2);
        chk("abort_live_busy", {31'd0, busy}, 32'd1);
        reset_mid_cycle("abort");
        run_pass(tbl[0], 0);

        // a pass after a failing one clears old results
        run_pass(tbl[2], 0);
        run_pass(tbl[0], 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
